// File: rtl/mips32_mem_port_arbiter.sv
// mips32_mem_port_arbiter: shares one memory port between IF fetch and MEM load/store.
// Optional build macro STARVE_GUARD_EN forces a fetch grant after STARVE_LIMIT data wins.
//
// Ports:
//   clk1, reset                  rising-edge clock, synchronous active-high reset
//   halted                       blocks new fetch grants
//   if_req/if_addr               fetch request  -> if_gnt, if_rvalid, if_rdata
//   dm_req/dm_we/dm_addr/wdata   data request   -> dm_gnt, dm_rvalid, dm_rdata
//   resp_err                     rvalid was caused by a memory timeout
//   stall_if                     fetch requested but not granted this cycle
//   mem_req/we/addr/wdata        memory command, held until mem_ack or timeout
//   mem_ack/mem_rdata            memory completion and read data
module mips32_mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          halted,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          resp_err,
    output logic          stall_if,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt;
    logic          lat_we;
    logic          busy;
    logic          arb_ok;
    logic          if_cand;
    logic          force_fetch;
    logic          timeout_hit;
    logic          done;

    assign busy    = (state != IDLE);
    assign arb_ok  = (state == IDLE) && !reset;
    assign if_cand = if_req && !halted;

    assign if_gnt   = arb_ok && if_cand && (!dm_req || force_fetch);
    assign dm_gnt   = arb_ok && dm_req && !if_gnt;
    assign stall_if = !reset && if_req && !if_gnt;

    // An ack in the final wait cycle still counts as a normal completion.
    assign timeout_hit = busy && !mem_ack && (wait_cnt == CW'(TIMEOUT));
    assign done        = busy && (mem_ack || timeout_hit);

    assign mem_req = busy;
    assign mem_we  = busy && lat_we;

`ifdef STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;

    assign force_fetch = (starve_cnt >= SW'(STARVE_LIMIT));

    // Saturates at the limit: once forced, the fetch wins and clears it.
    always_ff @(posedge clk1) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (arb_ok && if_cand && dm_gnt) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    // Strict data priority: never forces a fetch.
    assign force_fetch = (STARVE_LIMIT < 0);
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (if_gnt) begin
                    state_nx = FETCH;
                end else if (dm_gnt) begin
                    state_nx = DATA;
                end
            end
            FETCH, DATA: begin
                if (done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            resp_err  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state <= state_nx;
            if (if_gnt || dm_gnt) begin
                lat_we    <= dm_gnt && dm_we;
                mem_addr  <= if_gnt ? if_addr : dm_addr;
                mem_wdata <= dm_gnt ? dm_wdata : '0;
                wait_cnt  <= CW'(1);
            end else if (done) begin
                wait_cnt <= '0;
            end else if (busy) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if_rvalid <= done && (state == FETCH);
            dm_rvalid <= done && (state == DATA);
            resp_err  <= timeout_hit;
            if_rdata  <= (state == FETCH && mem_ack) ? mem_rdata : '0;
            dm_rdata  <= (state == DATA && mem_ack && !lat_we) ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mips32_mem_port_arbiter.sv
// Bench for mips32_mem_port_arbiter: directed scenarios plus random traffic
// against a transaction-level model of grants, memory windows and responses.
module tb_mips32_mem_port_arbiter;

    localparam int TO = 16;
    localparam int SL = 4;

    logic        clk1 = 1'b0;
    logic        reset;
    logic        halted;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        resp_err;
    logic        stall_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk1 = ~clk1;

    mips32_mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(TO), .STARVE_LIMIT(SL)
    ) dut (
        .clk1(clk1), .reset(reset), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .resp_err(resp_err), .stall_if(stall_if),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    // model state
    int          cyc     = 0;
    int          free_at = 0;
    bit          win_act = 0;
    int          win_lo, win_hi, ack_at;
    bit          a_we;
    logic [31:0] a_addr, a_wdata, a_rd;
    int          resp_at = -1;
    bit          r_fetch, r_err;
    logic [31:0] r_data;
    int          starve  = 0;

    // stimulus controls
    bit          rnd_mode = 0;
    int          force_lat = -1;
    bit          force_rd_en = 0;
    logic [31:0] force_rd;
    bit          if_keep = 0;
    bit          dm_keep = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle();
        bit idle, frc, eg_if, eg_dm, in_win, ack, rv_if, rv_dm;
        int lat;
        idle  = !reset && (cyc >= free_at);
        frc   = 1'b0;
`ifdef STARVE_GUARD_EN
        frc   = (starve >= SL);
`endif
        eg_if  = idle && if_req && !halted && (!dm_req || frc);
        eg_dm  = idle && dm_req && !eg_if;
        in_win = win_act && cyc >= win_lo && cyc <= win_hi;
        ack    = in_win && cyc == ack_at;
        mem_ack   = ack;
        mem_rdata = ack ? a_rd : $urandom;
        if (!in_win && rnd_mode && $urandom_range(0, 7) == 0)
            mem_ack = 1'b1;
        @(negedge clk1);
        if (!reset) begin
            rv_if = (resp_at == cyc) && r_fetch;
            rv_dm = (resp_at == cyc) && !r_fetch;
            chk("if_gnt", if_gnt, eg_if);
            chk("dm_gnt", dm_gnt, eg_dm);
            chk("stall_if", stall_if, if_req && !eg_if);
            chk("mem_req", mem_req, in_win);
            if (in_win) begin
                chk("mem_we", mem_we, a_we);
                chk("mem_addr", mem_addr, a_addr);
                if (a_we) chk("mem_wdata", mem_wdata, a_wdata);
            end
            chk("if_rvalid", if_rvalid, rv_if);
            chk("dm_rvalid", dm_rvalid, rv_dm);
            chk("resp_err", resp_err, (resp_at == cyc) && r_err);
            if (rv_if) chk("if_rdata", if_rdata, r_data);
            if (rv_dm) chk("dm_rdata", dm_rdata, r_data);
        end
        @(posedge clk1);
        if (reset) begin
            win_act = 0;
            resp_at = -1;
            free_at = cyc + 1;
            starve  = 0;
        end else begin
            if (eg_if) starve = 0;
            else if (idle && if_req && !halted && dm_req) starve++;
            if (eg_if || eg_dm) begin
                if (force_lat >= 0) begin
                    lat = force_lat;
                    force_lat = -1;
                end else if ($urandom_range(0, 3) == 0) begin
                    lat = $urandom_range(TO - 2, TO + 1);
                end else begin
                    lat = $urandom_range(0, 2);
                end
                a_rd = force_rd_en ? force_rd : $urandom;
                force_rd_en = 0;
                a_we    = eg_dm && dm_we;
                a_addr  = eg_if ? if_addr : dm_addr;
                a_wdata = dm_wdata;
                win_act = 1;
                win_lo  = cyc + 1;
                win_hi  = cyc + 1 + ((lat < TO - 1) ? lat : TO - 1);
                ack_at  = (lat <= TO - 1) ? cyc + 1 + lat : -1;
                free_at = win_hi + 1;
                resp_at = win_hi + 1;
                r_fetch = eg_if;
                r_err   = (lat > TO - 1);
                r_data  = (r_err || a_we) ? 32'h0 : a_rd;
            end
        end
        #1;
        cyc++;
        if (eg_if) begin
            if (if_keep) if_addr = $urandom;
            else if_req = 0;
        end
        if (eg_dm) begin
            if (dm_keep) begin
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end else begin
                dm_req = 0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1; halted = 0;
        if_req = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        @(posedge clk1);
        #1;
        run(2);
        reset = 0;
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_we", mem_we, 0);
        run(2);

        // single fetch, zero wait
        if_req = 1; if_addr = 5;
        force_lat = 0; force_rd_en = 1; force_rd = 32'h00221800;
        run(4);

        // collision: data wins, fetch follows
        if_req = 1; if_addr = 7;
        dm_req = 1; dm_we = 0; dm_addr = 100;
        force_lat = 0; force_rd_en = 1; force_rd = 555;
        run(6);

        // store
        dm_req = 1; dm_we = 1; dm_addr = 112; dm_wdata = 555;
        force_lat = 2;
        run(6);

        // timeout, then immediate new grant
        dm_req = 1; dm_we = 0; dm_addr = 40;
        force_lat = TO + 4;
        run(TO + 1);
        if_req = 1; if_addr = 3;
        run(4);

        // halted blocks fetch, data still served
        halted = 1; if_req = 1; if_addr = 20;
        run(8);
        dm_req = 1; dm_we = 0; dm_addr = 44;
        run(12);
        halted = 0;
        run(4);

        // reset in the middle of an access
        if_req = 1; if_addr = 9;
        force_lat = TO + 5;
        run(3);
        reset = 1;
        cycle();
        reset = 0;
        run(10);

        // continuous data traffic against a waiting fetch
        dm_keep = 1; dm_req = 1; dm_we = 0; dm_addr = 60;
        if_req = 1; if_addr = 77;
        run(60);
        dm_keep = 0;
        run(40);
        if_req = 0; dm_req = 0;
        run(TO + 4);

        // random traffic
        rnd_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end else if (if_req && $urandom_range(0, 19) == 0) begin
                if_req = 0;
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_we = $urandom_range(0, 1) == 1;
                dm_addr = $urandom; dm_wdata = $urandom;
            end else if (dm_req && $urandom_range(0, 19) == 0) begin
                dm_req = 0;
            end
            if ($urandom_range(0, 39) == 0) halted = !halted;
            reset = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rnd_mode = 0; reset = 0; halted = 0;
        if_req = 0; dm_req = 0;
        run(TO + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
